field_unpacker: RTL

FIELD_UNPACKER -- requirements
Module: field_unpacker

---
 rtl/field_unpacker.sv | 95 +++++++++
 1 files changed

// File: rtl/field_unpacker.sv
// rtl/field_unpacker.sv - splits a packed word into NF fields presented one per handshake
// Each field is sign- or zero-extended to OW bits according to SIGNED_MASK.
module field_unpacker #(
  parameter int FW = 8,
  parameter int NF = 4,
  parameter int OW = 16,
  parameter logic [NF-1:0] SIGNED_MASK = '1,
  localparam int IW = (NF > 1) ? $clog2(NF) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NF*FW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OW-1:0]    out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_sign,
  output logic             out_last
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NF - 1);

  state_t           state_q;
  logic [NF*FW-1:0] word_q;
  logic [IW-1:0]    idx_q;
  logic [OW-1:0]    data_q;
  logic             last_q;

  logic [FW-1:0]    in_fields   [NF];
  logic [FW-1:0]    held_fields [NF];
  logic [IW-1:0]    nxt_idx;
  logic             in_fire;
  logic             out_fire;

  function automatic logic [OW-1:0] extend(input logic [FW-1:0] f, input logic s);
    logic [OW-1:0] r;
    r = '0;
    r[FW-1:0] = f;
    for (int b = FW; b < OW; b++) r[b] = s & f[FW-1];
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NF; i++) begin
      in_fields[i]   = in_data[i*FW +: FW];
      held_fields[i] = word_q[i*FW +: FW];
    end
  end

  assign nxt_idx = idx_q + 1'b1;

  // Outputs are forced quiet while rst is high so no transfer can happen in a reset cycle.
  assign in_ready  = ~rst & ((state_q == IDLE) | ((state_q == EMIT) & out_ready & last_q));
  assign out_valid = ~rst & (state_q == EMIT);
  assign out_data  = rst ? '0 : data_q;
  assign out_idx   = rst ? '0 : idx_q;
  assign out_last  = ~rst & last_q;
  assign out_sign  = out_data[OW-1];

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_fire) begin
      // Covers both an idle capture and a capture coinciding with the last field.
      state_q <= EMIT;
      word_q  <= in_data;
      idx_q   <= '0;
      data_q  <= extend(in_fields[0], SIGNED_MASK[0]);
      last_q  <= 1'b0;
    end else if (out_fire) begin
      if (last_q) begin
        state_q <= IDLE;
        idx_q   <= '0;
        data_q  <= '0;
        last_q  <= 1'b0;
      end else begin
        idx_q  <= nxt_idx;
        data_q <= extend(held_fields[nxt_idx], SIGNED_MASK[nxt_idx]);
        last_q <= (nxt_idx == LAST_IDX);
      end
    end
  end

endmodule
